// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI widths, response codes and the DMA read-state type
package axi_pkg;
    localparam int AXI_IW     = 4;
    localparam int AXI_LW     = 8;
    localparam int AXI_SW     = 3;
    localparam int AXI_BURSTW = 2;
    localparam int AXI_WSTRBW = 16;
    localparam int AXI_BRESPW = 2;
    localparam logic [AXI_BRESPW-1:0] RESP_OKAY   = 2'd0;
    localparam logic [AXI_BRESPW-1:0] RESP_EXOKAY = 2'd1;
    localparam logic [AXI_BRESPW-1:0] RESP_SLVERR = 2'd2;
    localparam logic [AXI_BRESPW-1:0] RESP_DECERR = 2'd3;
    typedef enum logic {IDLE, BURST} dma_state_e;
endpackage

// File: rtl/dma_cmd_fifo.sv
// dma_cmd_fifo: synchronous show-ahead FIFO with full/empty flags
module dma_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    assign dout  = mem[rp];
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
endmodule

// File: rtl/axi_dma_wdata.sv
// axi_dma_wdata: reads DMA bursts from local RAM onto AXI W and tracks B completion
module axi_dma_wdata #(
    parameter int AXI_DW     = 128,
    parameter int RAM_AW     = 20,
    parameter int AXI_LW     = axi_pkg::AXI_LW,
    parameter int AXI_BRESPW = axi_pkg::AXI_BRESPW,
    parameter int AXI_IW     = axi_pkg::AXI_IW,
    parameter int CMDQ_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [RAM_AW-1:0]     src_sa,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AXI_LW-1:0]     cmd_len,
    input  logic                  cmd_last,
    output logic                  ram_re,
    output logic [RAM_AW-1:0]     ram_a,
    input  logic [AXI_DW-1:0]     ram_q,
    output logic [AXI_DW-1:0]     axi_wdata,
    output logic [AXI_DW/8-1:0]   axi_wstrb,
    output logic                  axi_wlast,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [AXI_IW-1:0]     axi_bid,
    input  logic [AXI_BRESPW-1:0] axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    import axi_pkg::*;
    localparam int OW = $clog2(CMDQ_DEPTH) + 3;
    dma_state_e state, state_nx;
    logic [AXI_LW:0] head;
    logic q_full, q_empty, q_pop;
    logic [AXI_LW-1:0] beat_cnt, beat_nx;
    logic last_burst, last_nx, rd, rd_last, rd_fin, re_d, last_d, fin_d;
    logic [RAM_AW-1:0] addr;
    logic [AXI_DW+1:0] ob [2];
    logic hd;
    logic [1:0] ob_cnt;
    logic w_hs, wl_hs, b_hs, room, final_sent, fin_nx, done_c, bid_unused;
    logic signed [OW-1:0] outst, out_nx;

    dma_cmd_fifo #(.WIDTH(AXI_LW+1), .DEPTH(CMDQ_DEPTH)) u_cmdq (
        .clk, .reset_n, .push(cmd_valid && !q_full), .din({cmd_last, cmd_len}),
        .pop(q_pop), .dout(head), .full(q_full), .empty(q_empty)
    );

    assign bid_unused = ^axi_bid;
    assign cmd_ready  = !q_full;
    assign axi_wvalid = ob_cnt != 2'd0;
    assign axi_wdata  = ob[hd][AXI_DW-1:0];
    assign axi_wlast  = ob[hd][AXI_DW];
    assign axi_wstrb  = '1;
    assign axi_bready = busy;
    assign ram_re     = rd;
    assign ram_a      = addr;
    assign w_hs       = axi_wvalid && axi_wready;
    assign wl_hs      = w_hs && axi_wlast;
    assign b_hs       = axi_bvalid && axi_bready;
    // a beat leaving the buffer this cycle frees a slot for the read issued now
    assign room       = ({1'b0, ob_cnt} + {2'b0, re_d}) < (3'd2 + {2'b0, w_hs});
    assign fin_nx     = final_sent || (wl_hs && ob[hd][AXI_DW+1]);
    assign out_nx     = outst + OW'(wl_hs) - OW'(b_hs);
    assign done_c     = busy && fin_nx && out_nx == '0;

    // beat_cnt holds remaining beats minus one, so a max-length burst fits
    always_comb begin
        state_nx = state;
        beat_nx  = beat_cnt;
        last_nx  = last_burst;
        q_pop    = 1'b0;
        rd       = 1'b0;
        rd_last  = 1'b0;
        rd_fin   = 1'b0;
        if (state == IDLE) begin
            if (busy && !q_empty && room) begin
                q_pop    = 1'b1;
                rd       = 1'b1;
                rd_last  = head[AXI_LW-1:0] == '0;
                rd_fin   = rd_last && head[AXI_LW];
                last_nx  = head[AXI_LW];
                beat_nx  = head[AXI_LW-1:0] - AXI_LW'(1);
                state_nx = rd_last ? IDLE : BURST;
            end
        end else if (room) begin
            rd      = 1'b1;
            rd_last = beat_cnt == '0;
            rd_fin  = rd_last && last_burst;
            beat_nx = beat_cnt - AXI_LW'(1);
            if (rd_last) begin
                q_pop    = !q_empty;
                beat_nx  = head[AXI_LW-1:0];
                last_nx  = head[AXI_LW];
                state_nx = q_empty ? IDLE : BURST;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_burst <= 1'b0;
            re_d       <= 1'b0;
            last_d     <= 1'b0;
            fin_d      <= 1'b0;
            addr       <= '0;
            ob[0]      <= '0;
            ob[1]      <= '0;
            hd         <= 1'b0;
            ob_cnt     <= '0;
            outst      <= '0;
            final_sent <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            beat_cnt   <= beat_nx;
            last_burst <= last_nx;
            re_d       <= rd;
            last_d     <= rd_last;
            fin_d      <= rd_fin;
            if (start && !busy) addr <= src_sa;
            else if (rd) addr <= addr + RAM_AW'(1);
            if (re_d) ob[hd ^ ob_cnt[0]] <= {fin_d, last_d, ram_q};
            if (w_hs) hd <= ~hd;
            ob_cnt     <= ob_cnt + {1'b0, re_d} - {1'b0, w_hs};
            outst      <= out_nx;
            final_sent <= fin_nx && !done_c;
            done       <= done_c;
            if (start && !busy) busy <= 1'b1;
            else if (done_c) busy <= 1'b0;
            if (start && !busy) err <= 1'b0;
            else if (b_hs && axi_bresp != RESP_OKAY) err <= 1'b1;
        end
endmodule

// File: tb/tb_axi_dma_wdata.sv
// tb_axi_dma_wdata: scoreboard bench for the W/B data mover
module tb_axi_dma_wdata;
    logic clk, reset_n, start, cmd_valid, cmd_ready, cmd_last, ram_re;
    logic [19:0] src_sa, ram_a;
    logic [7:0] cmd_len;
    logic [127:0] ram_q, axi_wdata;
    logic [15:0] axi_wstrb;
    logic axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready, busy, done, err;
    logic [3:0] axi_bid;
    logic [1:0] axi_bresp;

    axi_dma_wdata dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_sa(src_sa),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_last(cmd_last),
        .ram_re(ram_re), .ram_a(ram_a), .ram_q(ram_q),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .busy(busy), .done(done), .err(err)
    );

    int errors = 0, checks = 0, cyc = 0;
    int bursts, b_got, wl_cnt, b_sent, dn_cnt, push_cyc, first_wv;
    bit chk_en, final_pushed, m_busy, m_done, m_err, prev_stall, wr_rand, b_en;
    logic [19:0] m_addr;
    logic [19:0] exp_a[$];
    logic [128:0] exp_w[$];
    logic [128:0] prev_w;
    logic [19:0] a_log[$];
    int w_cyc[$];
    logic [1:0] bresp_tab[16];

    task automatic chk(string name, logic [135:0] act, logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dfn(logic [19:0] a);
        return {~{12'h0, a}, 12'hABC, a, 12'h123, a, 12'h0, a};
    endfunction

    initial clk = 0;
    always #5 clk = ~clk;

    // RAM with one-cycle read latency
    always @(posedge clk) ram_q <= ram_re ? dfn(ram_a) : '0;

    always begin
        @(posedge clk); #1;
        axi_wready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // one B per observed wlast, responses taken from bresp_tab in burst order
    always begin
        @(posedge clk); #1;
        if (reset_n && b_en && wl_cnt > b_sent) begin
            axi_bvalid = 1'b1;
            axi_bresp  = bresp_tab[b_sent];
            b_sent++;
        end else begin
            axi_bvalid = 1'b0;
            axi_bresp  = 2'd0;
        end
    end

    always @(negedge clk) begin
        bit nd;
        cyc++;
        if (done) dn_cnt++;
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("bready", axi_bready, m_busy);
            if (ram_re) begin
                a_log.push_back(ram_a);
                chk("read_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) chk("ram_a", ram_a, exp_a.pop_front());
            end
            if (prev_stall) chk("w_stable", {axi_wvalid, axi_wlast, axi_wdata}, {1'b1, prev_w});
            if (axi_wvalid && axi_wready) begin
                w_cyc.push_back(cyc);
                if (first_wv < 0) first_wv = cyc;
                chk("beat_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) chk("wbeat", {axi_wlast, axi_wdata}, exp_w.pop_front());
                if (axi_wlast) wl_cnt++;
            end
            prev_stall = axi_wvalid && !axi_wready;
            prev_w = {axi_wlast, axi_wdata};
            if (axi_bvalid && m_busy) b_got++;
            if (cmd_valid && cmd_ready) begin
                push_cyc = cyc;
                for (int i = 0; i <= int'(cmd_len); i++) begin
                    exp_a.push_back(m_addr);
                    exp_w.push_back({i == int'(cmd_len), dfn(m_addr)});
                    m_addr = m_addr + 20'd1;
                end
                bursts++;
                if (cmd_last) final_pushed = 1;
            end
            nd = m_busy && final_pushed && exp_w.size() == 0 && b_got == bursts;
            m_err = (start && !m_busy) ? 1'b0 : (m_err | (axi_bvalid && m_busy && axi_bresp != 2'd0));
            if (start && !m_busy) begin
                m_busy = 1; m_addr = src_sa; bursts = 0; b_got = 0; final_pushed = 0;
                wl_cnt = 0; b_sent = 0;
            end else if (nd) m_busy = 0;
            m_done = nd;
        end
    end

    task automatic step(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start(logic [19:0] a);
        start = 1; src_sa = a; step(1); start = 0;
    endtask

    task automatic push(logic [7:0] len, logic last);
        cmd_valid = 1; cmd_len = len; cmd_last = last; step(1); cmd_valid = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (busy && t < 2000) begin step(1); t++; end
        chk("timeout", busy, 0);
        step(3);
    endtask

    task automatic clr_logs();
        a_log.delete(); w_cyc.delete(); first_wv = -1; dn_cnt = 0;
    endtask

    task automatic reset_chk(string tag);
        chk({tag, "_ctl"}, {ram_re, cmd_ready, axi_wvalid, axi_wlast, axi_bready, busy, done, err}, 8'b0100_0000);
        chk({tag, "_ram_a"}, ram_a, 20'h0);
        chk({tag, "_wdata"}, axi_wdata, 128'h0);
        chk({tag, "_wstrb"}, axi_wstrb, 16'hFFFF);
    endtask

    initial begin
        reset_n = 0; start = 0; src_sa = 0; cmd_valid = 0; cmd_len = 0; cmd_last = 0;
        axi_bid = 0; axi_bresp = 0; axi_bvalid = 0; axi_wready = 1;
        wr_rand = 0; b_en = 1; chk_en = 0; first_wv = -1;
        bursts = 0; b_got = 0; wl_cnt = 0; b_sent = 0; dn_cnt = 0; push_cyc = 0;
        final_pushed = 0; m_busy = 0; m_done = 0; m_err = 0; prev_stall = 0; m_addr = 0;
        foreach (bresp_tab[i]) bresp_tab[i] = 2'd0;
        step(3);
        reset_chk("reset");
        reset_n = 1;
        step(1);
        chk_en = 1;

        clr_logs();
        do_start(20'h100);
        push(8'd3, 1'b1);
        wait_done();
        chk("t1_reads", a_log.size(), 4);
        chk("t1_a0", a_log[0], 20'h100);
        chk("t1_a3", a_log[3], 20'h103);
        chk("t1_beats", w_cyc.size(), 4);
        chk("t1_latency", first_wv - push_cyc, 3);
        chk("t1_done", dn_cnt, 1);
        chk("t1_err", err, 0);

        clr_logs();
        do_start(20'h0);
        push(8'd15, 1'b0);
        push(8'd15, 1'b0);
        push(8'd7, 1'b1);
        wait_done();
        chk("t2_beats", w_cyc.size(), 40);
        chk("t2_nogap", w_cyc[39] - w_cyc[0], 39);
        chk("t2_done", dn_cnt, 1);

        clr_logs();
        wr_rand = 1;
        do_start(20'h2000);
        push(8'd7, 1'b0);
        push(8'd7, 1'b1);
        wait_done();
        wr_rand = 0;
        chk("t3_beats", w_cyc.size(), 16);
        chk("t3_done", dn_cnt, 1);

        clr_logs();
        do_start(20'hFFFFE);
        push(8'd3, 1'b1);
        wait_done();
        chk("t4_a0", a_log[0], 20'hFFFFE);
        chk("t4_a1", a_log[1], 20'hFFFFF);
        chk("t4_a2", a_log[2], 20'h00000);
        chk("t4_a3", a_log[3], 20'h00001);

        clr_logs();
        bresp_tab[1] = 2'd2;
        do_start(20'h300);
        push(8'd1, 1'b0);
        push(8'd2, 1'b1);
        wait_done();
        chk("t5_err", err, 1);
        chk("t5_done", dn_cnt, 1);
        bresp_tab[1] = 2'd0;
        clr_logs();
        do_start(20'h400);
        chk("t5_err_clr", err, 0);
        push(8'd0, 1'b1);
        wait_done();
        chk("t5_single", w_cyc.size(), 1);
        chk("t5_single_a", a_log[0], 20'h400);

        clr_logs();
        do_start(20'h500);
        push(8'd7, 1'b0);
        push(8'd7, 1'b1);
        step(4);
        chk_en = 0;
        reset_n = 0;
        #1;
        reset_chk("midrst");
        exp_a.delete(); exp_w.delete();
        bursts = 0; b_got = 0; wl_cnt = 0; b_sent = 0; final_pushed = 0;
        m_busy = 0; m_done = 0; m_err = 0; prev_stall = 0;
        step(3);
        reset_chk("midrst_hold");
        dn_cnt = 0;
        reset_n = 1;
        step(1);
        chk_en = 1;
        step(3);
        chk("t6_nodone", dn_cnt, 0);
        clr_logs();
        do_start(20'h600);
        push(8'd2, 1'b1);
        wait_done();
        chk("t6_a0", a_log[0], 20'h600);
        chk("t6_beats", w_cyc.size(), 3);
        chk("t6_done", dn_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
